apb_fsm_controller: RTL and testbench

Sequencing controller of the AHB-to-APB bridge. Takes the decoded, range-checked AHB transfer request from the AHB slave interface (`valid`, address, direction, write data, one-hot slave select). Drives a standard two-phase APB transfer (SETUP, then ACCESS with `pready` wait states) to one of three APB slaves. Stalls the AHB master via `hreadyout` and returns read data and OKAY/ERROR response, including a bounded-wait timeout.

---
 rtl/apb_bridge_pkg.sv | 27 ++
 rtl/apb_wait_timer.sv | 30 +++
 rtl/apb_fsm_controller.sv | 143 ++++++++++++++
 tb/tb_apb_fsm_controller.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_bridge_pkg.sv
// Shared types and constants for the AHB-to-APB bridge sequencing logic.
package apb_bridge_pkg;

  localparam int ADDR_W_DEF   = 32;
  localparam int DATA_W_DEF   = 32;
  localparam int NSLV_DEF     = 3;
  localparam int WAIT_MAX_DEF = 16;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WWAIT,
    ST_SETUP,
    ST_ACCESS,
    ST_DONE,
    ST_ERR1,
    ST_ERR2
  } apb_state_e;

  // States in which the AHB side may present a new address phase.
  function automatic logic ahb_ready(apb_state_e s);
    return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERR2);
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Counts APB wait cycles within one ACCESS phase and flags the cycle that
// reaches the WAIT_MAX limit so the controller can abandon the transfer.
module apb_wait_timer #(
  parameter int WAIT_MAX = 16
) (
  input  logic hclk,
  input  logic hreset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(WAIT_MAX + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != CNT_W'(WAIT_MAX))) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // High during the wait cycle whose increment brings the count to WAIT_MAX.
  assign expired = enable && (cnt == CNT_W'(WAIT_MAX - 1));

endmodule

// File: rtl/apb_fsm_controller.sv
// APB sequencing controller of the AHB-to-APB bridge: two-phase APB transfers
// with wait states, AHB stall via hreadyout, OKAY/ERROR response and timeout.
module apb_fsm_controller
  import apb_bridge_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NSLV     = NSLV_DEF,
  parameter int WAIT_MAX = WAIT_MAX_DEF
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              valid,
  input  logic [ADDR_W-1:0] haddr,
  input  logic              hwrite,
  input  logic [DATA_W-1:0] hwdata,
  input  logic [NSLV-1:0]   temp_selx,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr,
  output logic [NSLV-1:0]   pselx,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic              hreadyout,
  output logic [1:0]        hresp,
  output logic [DATA_W-1:0] hrdata
);

  apb_state_e      state;
  apb_state_e      state_n;
  logic [NSLV-1:0] sel_q;
  logic            addr_latch;
  logic            wdata_latch;
  logic            rd_capture;
  logic            timer_clr;
  logic            timer_en;
  logic            timer_expired;

  apb_wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait_timer (
    .hclk    (hclk),
    .hreset  (hreset),
    .clear   (timer_clr),
    .enable  (timer_en),
    .expired (timer_expired)
  );

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Outputs decode the registered state only; inputs steer next state and latches.
  always_comb begin
    state_n     = state;
    pselx       = '0;
    penable     = 1'b0;
    hreadyout   = ahb_ready(state);
    hresp       = HRESP_OKAY;
    addr_latch  = 1'b0;
    wdata_latch = 1'b0;
    rd_capture  = 1'b0;
    timer_clr   = 1'b0;
    timer_en    = 1'b0;

    case (state)
      ST_IDLE, ST_DONE, ST_ERR2: begin
        if (state == ST_ERR2) begin
          hresp = HRESP_ERROR;
        end
        if (valid) begin
          addr_latch = 1'b1;
          state_n    = hwrite ? ST_WWAIT : ST_SETUP;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_WWAIT: begin
        wdata_latch = 1'b1;
        state_n     = ST_SETUP;
      end
      ST_SETUP: begin
        pselx     = sel_q;
        timer_clr = 1'b1;
        state_n   = ST_ACCESS;
      end
      ST_ACCESS: begin
        pselx   = sel_q;
        penable = 1'b1;
        if (pready) begin
          if (pslverr) begin
            state_n = ST_ERR1;
          end else begin
            rd_capture = !pwrite;
            state_n    = ST_DONE;
          end
        end else begin
          timer_en = 1'b1;
          if (timer_expired) begin
            state_n = ST_ERR1;
          end
        end
      end
      ST_ERR1: begin
        hresp   = HRESP_ERROR;
        state_n = ST_ERR2;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Transfer attributes hold between transfers and move only on their latch.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      paddr  <= '0;
      pwrite <= 1'b0;
      sel_q  <= '0;
      pwdata <= '0;
      hrdata <= '0;
    end else begin
      if (addr_latch) begin
        paddr  <= haddr;
        pwrite <= hwrite;
        sel_q  <= temp_selx;
      end
      if (wdata_latch) begin
        pwdata <= hwdata;
      end
      if (rd_capture) begin
        hrdata <= prdata;
      end
    end
  end

endmodule

// File: tb/tb_apb_fsm_controller.sv
// Directed bench for apb_fsm_controller: per-cycle vector table plus
// hand-written timeout and asynchronous-reset sequences.
module tb_apb_fsm_controller;

  logic        hclk;
  logic        hreset;
  logic        valid;
  logic [31:0] haddr;
  logic        hwrite;
  logic [31:0] hwdata;
  logic [2:0]  temp_selx;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic [2:0]  pselx;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        hreadyout;
  logic [1:0]  hresp;
  logic [31:0] hrdata;

  int n_tests = 0;
  int n_fail  = 0;

  apb_fsm_controller dut (
    .hclk      (hclk),
    .hreset    (hreset),
    .valid     (valid),
    .haddr     (haddr),
    .hwrite    (hwrite),
    .hwdata    (hwdata),
    .temp_selx (temp_selx),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr),
    .pselx     (pselx),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .hreadyout (hreadyout),
    .hresp     (hresp),
    .hrdata    (hrdata)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  typedef struct {
    logic        valid;
    logic [31:0] haddr;
    logic        hwrite;
    logic [31:0] hwdata;
    logic [2:0]  sel;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic [2:0]  e_pselx;
    logic        e_penable;
    logic        e_pwrite;
    logic [31:0] e_paddr;
    logic [31:0] e_pwdata;
    logic        e_hready;
    logic [1:0]  e_hresp;
    logic [31:0] e_hrdata;
  } vec_t;

  vec_t vecs[$];

  // Inputs are applied for one clock; expectations are the outputs after that edge.
  function automatic vec_t v(input logic [31:0] vl, input logic [31:0] ad, input logic [31:0] wr,
                             input logic [31:0] wd, input logic [31:0] sl, input logic [31:0] rd,
                             input logic [31:0] rdy, input logic [31:0] er,
                             input logic [31:0] eps, input logic [31:0] epe, input logic [31:0] epw,
                             input logic [31:0] epa, input logic [31:0] epd, input logic [31:0] ehr,
                             input logic [31:0] ehs, input logic [31:0] ehd);
    vec_t r;
    r.valid     = vl[0];
    r.haddr     = ad;
    r.hwrite    = wr[0];
    r.hwdata    = wd;
    r.sel       = sl[2:0];
    r.prdata    = rd;
    r.pready    = rdy[0];
    r.pslverr   = er[0];
    r.e_pselx   = eps[2:0];
    r.e_penable = epe[0];
    r.e_pwrite  = epw[0];
    r.e_paddr   = epa;
    r.e_pwdata  = epd;
    r.e_hready  = ehr[0];
    r.e_hresp   = ehs[1:0];
    r.e_hrdata  = ehd;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic idle_inputs();
    valid     = 1'b0;
    haddr     = '0;
    hwrite    = 1'b0;
    hwdata    = '0;
    temp_selx = '0;
    prdata    = '0;
    pready    = 1'b0;
    pslverr   = 1'b0;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, ".pselx"},     32'(pselx),     32'd0);
    chk({tag, ".penable"},   32'(penable),   32'd0);
    chk({tag, ".pwrite"},    32'(pwrite),    32'd0);
    chk({tag, ".paddr"},     paddr,          32'd0);
    chk({tag, ".pwdata"},    pwdata,         32'd0);
    chk({tag, ".hreadyout"}, 32'(hreadyout), 32'd1);
    chk({tag, ".hresp"},     32'(hresp),     32'd0);
    chk({tag, ".hrdata"},    hrdata,         32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_acc;
    // write 0-wait, read 2-wait, slave error, back-to-back from DONE and from ERR2
    vecs.push_back(v(1, 32'h84000010, 1, 0,            2, 0,            0, 0, 0, 0, 1, 32'h84000010, 0,            0, 0, 0));
    vecs.push_back(v(0, 0,            0, 32'hDEADBEEF, 0, 0,            0, 0, 2, 0, 1, 32'h84000010, 32'hDEADBEEF, 0, 0, 0));
    vecs.push_back(v(0, 0,            0, 0,            0, 0,            1, 0, 2, 1, 1, 32'h84000010, 32'hDEADBEEF, 0, 0, 0));
    vecs.push_back(v(0, 0,            0, 0,            0, 0,            1, 0, 0, 0, 1, 32'h84000010, 32'hDEADBEEF, 1, 0, 0));
    vecs.push_back(v(0, 0,            0, 0,            0, 0,            0, 0, 0, 0, 1, 32'h84000010, 32'hDEADBEEF, 1, 0, 0));
    vecs.push_back(v(1, 32'h80000004, 0, 0,            1, 0,            0, 0, 1, 0, 0, 32'h80000004, 32'hDEADBEEF, 0, 0, 0));
    vecs.push_back(v(0, 0,            0, 32'h11111111, 0, 0,            0, 0, 1, 1, 0, 32'h80000004, 32'hDEADBEEF, 0, 0, 0));
    vecs.push_back(v(0, 0,            0, 0,            0, 0,            0, 0, 1, 1, 0, 32'h80000004, 32'hDEADBEEF, 0, 0, 0));
    vecs.push_back(v(0, 0,            0, 0,            0, 0,            0, 0, 1, 1, 0, 32'h80000004, 32'hDEADBEEF, 0, 0, 0));
    vecs.push_back(v(0, 0,            0, 0,            0, 32'h12345678, 1, 0, 0, 0, 0, 32'h80000004, 32'hDEADBEEF, 1, 0, 32'h12345678));
    vecs.push_back(v(0, 0,            0, 0,            0, 0,            0, 0, 0, 0, 0, 32'h80000004, 32'hDEADBEEF, 1, 0, 32'h12345678));
    vecs.push_back(v(1, 32'h80000008, 0, 0,            1, 0,            0, 0, 1, 0, 0, 32'h80000008, 32'hDEADBEEF, 0, 0, 32'h12345678));
    vecs.push_back(v(0, 0,            0, 0,            0, 0,            0, 0, 1, 1, 0, 32'h80000008, 32'hDEADBEEF, 0, 0, 32'h12345678));
    vecs.push_back(v(0, 0,            0, 0,            0, 32'hAAAA5555, 1, 1, 0, 0, 0, 32'h80000008, 32'hDEADBEEF, 0, 1, 32'h12345678));
    vecs.push_back(v(0, 0,            0, 0,            0, 0,            0, 0, 0, 0, 0, 32'h80000008, 32'hDEADBEEF, 1, 1, 32'h12345678));
    vecs.push_back(v(0, 0,            0, 0,            0, 0,            0, 0, 0, 0, 0, 32'h80000008, 32'hDEADBEEF, 1, 0, 32'h12345678));
    vecs.push_back(v(1, 32'h84000020, 1, 0,            2, 0,            0, 0, 0, 0, 1, 32'h84000020, 32'hDEADBEEF, 0, 0, 32'h12345678));
    vecs.push_back(v(0, 0,            0, 32'hCAFEF00D, 0, 0,            0, 0, 2, 0, 1, 32'h84000020, 32'hCAFEF00D, 0, 0, 32'h12345678));
    vecs.push_back(v(0, 0,            0, 0,            0, 0,            0, 0, 2, 1, 1, 32'h84000020, 32'hCAFEF00D, 0, 0, 32'h12345678));
    vecs.push_back(v(0, 0,            0, 0,            0, 0,            1, 0, 0, 0, 1, 32'h84000020, 32'hCAFEF00D, 1, 0, 32'h12345678));
    vecs.push_back(v(1, 32'h88000000, 0, 0,            4, 0,            0, 0, 4, 0, 0, 32'h88000000, 32'hCAFEF00D, 0, 0, 32'h12345678));
    vecs.push_back(v(0, 0,            0, 0,            0, 0,            0, 0, 4, 1, 0, 32'h88000000, 32'hCAFEF00D, 0, 0, 32'h12345678));
    vecs.push_back(v(0, 0,            0, 0,            0, 32'h0BADC0DE, 1, 0, 0, 0, 0, 32'h88000000, 32'hCAFEF00D, 1, 0, 32'h0BADC0DE));
    vecs.push_back(v(0, 0,            0, 0,            0, 0,            0, 0, 0, 0, 0, 32'h88000000, 32'hCAFEF00D, 1, 0, 32'h0BADC0DE));
    vecs.push_back(v(1, 32'h84000030, 1, 0,            2, 0,            0, 0, 0, 0, 1, 32'h84000030, 32'hCAFEF00D, 0, 0, 32'h0BADC0DE));
    vecs.push_back(v(0, 0,            0, 32'h01020304, 0, 0,            0, 0, 2, 0, 1, 32'h84000030, 32'h01020304, 0, 0, 32'h0BADC0DE));
    vecs.push_back(v(0, 0,            0, 0,            0, 0,            0, 0, 2, 1, 1, 32'h84000030, 32'h01020304, 0, 0, 32'h0BADC0DE));
    vecs.push_back(v(0, 0,            0, 0,            0, 0,            1, 1, 0, 0, 1, 32'h84000030, 32'h01020304, 0, 1, 32'h0BADC0DE));
    vecs.push_back(v(0, 0,            0, 0,            0, 0,            0, 0, 0, 0, 1, 32'h84000030, 32'h01020304, 1, 1, 32'h0BADC0DE));
    vecs.push_back(v(1, 32'h80000020, 0, 0,            1, 0,            0, 0, 1, 0, 0, 32'h80000020, 32'h01020304, 0, 0, 32'h0BADC0DE));
    vecs.push_back(v(0, 0,            0, 0,            0, 0,            0, 0, 1, 1, 0, 32'h80000020, 32'h01020304, 0, 0, 32'h0BADC0DE));
    vecs.push_back(v(0, 0,            0, 0,            0, 32'hFEEDFACE, 1, 0, 0, 0, 0, 32'h80000020, 32'h01020304, 1, 0, 32'hFEEDFACE));
    vecs.push_back(v(0, 0,            0, 0,            0, 0,            0, 0, 0, 0, 0, 32'h80000020, 32'h01020304, 1, 0, 32'hFEEDFACE));

    idle_inputs();
    hreset = 1'b1;
    step();
    step();
    chk_reset_values("reset");
    hreset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      valid     = vecs[i].valid;
      haddr     = vecs[i].haddr;
      hwrite    = vecs[i].hwrite;
      hwdata    = vecs[i].hwdata;
      temp_selx = vecs[i].sel;
      prdata    = vecs[i].prdata;
      pready    = vecs[i].pready;
      pslverr   = vecs[i].pslverr;
      step();
      chk($sformatf("row%0d.pselx", i),     32'(pselx),     32'(vecs[i].e_pselx));
      chk($sformatf("row%0d.penable", i),   32'(penable),   32'(vecs[i].e_penable));
      chk($sformatf("row%0d.pwrite", i),    32'(pwrite),    32'(vecs[i].e_pwrite));
      chk($sformatf("row%0d.paddr", i),     paddr,          vecs[i].e_paddr);
      chk($sformatf("row%0d.pwdata", i),    pwdata,         vecs[i].e_pwdata);
      chk($sformatf("row%0d.hreadyout", i), 32'(hreadyout), 32'(vecs[i].e_hready));
      chk($sformatf("row%0d.hresp", i),     32'(hresp),     32'(vecs[i].e_hresp));
      chk($sformatf("row%0d.hrdata", i),    hrdata,         vecs[i].e_hrdata);
    end

    // Timeout: pready held low for the whole ACCESS phase.
    idle_inputs();
    valid     = 1'b1;
    haddr     = 32'h80000010;
    temp_selx = 3'b001;
    step();
    idle_inputs();
    step();
    n_acc = 0;
    while (penable && n_acc < 40) begin
      n_acc++;
      step();
    end
    chk("timeout.access_cycles", 32'(n_acc),     32'd16);
    chk("timeout.err1.pselx",    32'(pselx),     32'd0);
    chk("timeout.err1.penable",  32'(penable),   32'd0);
    chk("timeout.err1.hready",   32'(hreadyout), 32'd0);
    chk("timeout.err1.hresp",    32'(hresp),     32'd1);
    chk("timeout.err1.hrdata",   hrdata,         32'hFEEDFACE);
    step();
    chk("timeout.err2.hready",   32'(hreadyout), 32'd1);
    chk("timeout.err2.hresp",    32'(hresp),     32'd1);
    step();
    chk("timeout.idle.hresp",    32'(hresp),     32'd0);

    // Following transfer after a timeout completes normally with one wait state.
    valid     = 1'b1;
    haddr     = 32'h80000014;
    temp_selx = 3'b001;
    step();
    idle_inputs();
    step();
    chk("post_to.access.penable", 32'(penable), 32'd1);
    step();
    chk("post_to.wait.penable",   32'(penable), 32'd1);
    pready = 1'b1;
    prdata = 32'h13579BDF;
    step();
    idle_inputs();
    chk("post_to.done.hready", 32'(hreadyout), 32'd1);
    chk("post_to.done.hresp",  32'(hresp),     32'd0);
    chk("post_to.done.hrdata", hrdata,         32'h13579BDF);
    step();

    // Asynchronous reset asserted mid-ACCESS, away from any clock edge.
    valid     = 1'b1;
    haddr     = 32'h84000040;
    hwrite    = 1'b1;
    temp_selx = 3'b100;
    step();
    idle_inputs();
    hwdata = 32'h77777777;
    step();
    idle_inputs();
    step();
    chk("rst_mid.access.penable", 32'(penable), 32'd1);
    #2;
    hreset = 1'b1;
    #1;
    chk_reset_values("rst_mid");
    step();
    hreset = 1'b0;
    step();
    chk("rst_mid.after.hready", 32'(hreadyout), 32'd1);
    chk("rst_mid.after.pselx",  32'(pselx),     32'd0);
    chk("rst_mid.after.hresp",  32'(hresp),     32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
